// File: rtl/rate_auto_sequencer_pkg.sv
// ============================================================================
//  rate_sel_pkg
//  Shared rate-select codes and sequencer state encoding.
//  Revision: 1.0
// ============================================================================
`default_nettype none

package rate_sel_pkg;

    localparam logic [1:0] SEL_05HZ = 2'b00;
    localparam logic [1:0] SEL_1HZ  = 2'b01;
    localparam logic [1:0] SEL_2HZ  = 2'b10;
    localparam logic [1:0] SEL_10HZ = 2'b11;

    typedef enum logic [1:0] {
        S_AUTO   = 2'd0,
        S_MANUAL = 2'd1,
        S_SWITCH = 2'd2
    } state_e;

endpackage

`default_nettype wire

// File: rtl/rate_auto_sequencer_sync_ff.sv
// ============================================================================
//  sync_ff
//  N-stage flop synchroniser for asynchronous switch inputs; clears to 0.
//  Revision: 1.0
// ============================================================================
`default_nettype none

module sync_ff #(
    parameter int WIDTH  = 1,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [STAGES-1:0][WIDTH-1:0] sync_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= '0;
        end else begin
            sync_q[0] <= d_i;
            for (int i = 1; i < STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
        end
    end

    assign q_o = sync_q[STAGES-1];

endmodule

`default_nettype wire

// File: rtl/rate_auto_sequencer.sv
// ============================================================================
//  rate_auto_sequencer
//  Owns the tick-mux rate select and the 0..COUNT_MAX count; AUTO/MANUAL FSM.
//  Revision: 1.0
// ============================================================================
`default_nettype none

module rate_auto_sequencer
    import rate_sel_pkg::*;
#(
    parameter int COUNT_MAX       = 31,
    parameter int CNT_W           = 5,
    parameter int ROUNDS_PER_RATE = 1,
    parameter int SYNC_STAGES     = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             tick_in,
    input  logic             auto_en,
    input  logic [1:0]       man_sel,
    output logic [1:0]       sel,
    output logic [CNT_W-1:0] count,
    output logic             wrap,
    output logic             mode_auto
);

    localparam int               RND_W    = (ROUNDS_PER_RATE > 1) ? $clog2(ROUNDS_PER_RATE) : 1;
    localparam logic [RND_W-1:0] RND_LAST = RND_W'(ROUNDS_PER_RATE - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(COUNT_MAX);

    logic [2:0]       sync_w;
    logic             a_s;
    logic [1:0]       m_s;
    logic             a_d_q;
    state_e           state_q, state_d;
    logic [1:0]       sel_q, sel_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [RND_W-1:0] round_q, round_d;
    logic             wrap_q, wrap_d;
    logic             mode_auto_q;
    logic             at_max_w;

    sync_ff #(
        .WIDTH  (3),
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .clk (clk),
        .rst (rst),
        .d_i ({auto_en, man_sel}),
        .q_o (sync_w)
    );

    assign a_s      = sync_w[2];
    assign m_s      = sync_w[1:0];
    assign at_max_w = (count_q == CNT_LAST);

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        count_d = count_q;
        round_d = round_q;
        wrap_d  = 1'b0;

        // A synced mode edge wins over everything else, including a tick.
        if (a_s != a_d_q) begin
            state_d = S_SWITCH;
            count_d = '0;
            round_d = '0;
        end else begin
            case (state_q)
                S_AUTO: begin
                    if (tick_in) begin
                        if (at_max_w) begin
                            count_d = '0;
                            wrap_d  = 1'b1;
                            if (round_q == RND_LAST) begin
                                round_d = '0;
                                sel_d   = sel_q + 2'd1;
                            end else begin
                                round_d = round_q + RND_W'(1);
                            end
                        end else begin
                            count_d = count_q + CNT_W'(1);
                        end
                    end
                end
                S_MANUAL: begin
                    if (m_s != sel_q) begin
                        sel_d   = m_s;
                        count_d = '0;
                        round_d = '0;
                    end else if (tick_in) begin
                        if (at_max_w) begin
                            count_d = '0;
                            wrap_d  = 1'b1;
                        end else begin
                            count_d = count_q + CNT_W'(1);
                        end
                    end
                end
                S_SWITCH: begin
                    count_d = '0;
                    round_d = '0;
                    if (a_s) begin
                        state_d = S_AUTO;
                    end else begin
                        state_d = S_MANUAL;
                        sel_d   = m_s;
                    end
                end
                default: begin
                    state_d = S_AUTO;
                    count_d = '0;
                    round_d = '0;
                end
            endcase
        end
    end

    // a_d clears to 0, so releasing reset with auto_en high costs one
    // harmless S_SWITCH pass back into S_AUTO once the synchroniser fills.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_AUTO;
            sel_q       <= SEL_05HZ;
            count_q     <= '0;
            round_q     <= '0;
            wrap_q      <= 1'b0;
            mode_auto_q <= 1'b1;
            a_d_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            sel_q       <= sel_d;
            count_q     <= count_d;
            round_q     <= round_d;
            wrap_q      <= wrap_d;
            mode_auto_q <= (state_d == S_AUTO);
            a_d_q       <= a_s;
        end
    end

    assign sel       = sel_q;
    assign count     = count_q;
    assign wrap      = wrap_q;
    assign mode_auto = mode_auto_q;

endmodule

`default_nettype wire

// File: tb/tb_rate_auto_sequencer.sv
// ============================================================================
//  tb_rate_auto_sequencer
//  Directed, table-driven bench; dut1 uses 1 round per rate, dut2 uses 2.
//  Revision: 1.0
// ============================================================================
`default_nettype none

module tb_rate_auto_sequencer;

    logic       clk = 1'b0;
    logic       rst;
    logic       tick_in;
    logic       auto_en;
    logic [1:0] man_sel;
    logic [1:0] sel1, sel2;
    logic [4:0] count1, count2;
    logic       wrap1, wrap2;
    logic       mode1, mode2;

    int n_pass  = 0;
    int n_total = 0;
    int wcnt    = 0;

    always #5 clk = ~clk;

    rate_auto_sequencer #(.COUNT_MAX(31), .CNT_W(5), .ROUNDS_PER_RATE(1), .SYNC_STAGES(2)) dut1 (
        .clk(clk), .rst(rst), .tick_in(tick_in), .auto_en(auto_en), .man_sel(man_sel),
        .sel(sel1), .count(count1), .wrap(wrap1), .mode_auto(mode1)
    );

    rate_auto_sequencer #(.COUNT_MAX(31), .CNT_W(5), .ROUNDS_PER_RATE(2), .SYNC_STAGES(2)) dut2 (
        .clk(clk), .rst(rst), .tick_in(tick_in), .auto_en(auto_en), .man_sel(man_sel),
        .sel(sel2), .count(count2), .wrap(wrap2), .mode_auto(mode2)
    );

    always @(negedge clk) if (wrap1) wcnt++;

    typedef struct {
        int         ticks;
        logic [4:0] exp_count;
        logic [1:0] exp_sel1;
        logic [1:0] exp_sel2;
        logic       exp_wrap;
        int         exp_wraps;
    } vec_t;

    task automatic chk(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Ticks on alternate cycles; returns 1 time unit after the edge that took the last tick.
    task automatic apply_ticks(input int n);
        for (int i = 0; i < n; i++) begin
            tick_in = 1'b1;
            cyc();
            tick_in = 1'b0;
            if (i < n - 1) cyc();
        end
    endtask

    vec_t vecs[7];

    initial begin
        vecs[0] = '{31, 5'd31, 2'd0, 2'd0, 1'b0, 0};
        vecs[1] = '{1,  5'd0,  2'd1, 2'd0, 1'b1, 1};
        vecs[2] = '{32, 5'd0,  2'd2, 2'd1, 1'b1, 2};
        vecs[3] = '{32, 5'd0,  2'd3, 2'd1, 1'b1, 3};
        vecs[4] = '{32, 5'd0,  2'd0, 2'd2, 1'b1, 4};
        vecs[5] = '{64, 5'd0,  2'd2, 2'd3, 1'b1, 6};
        vecs[6] = '{17, 5'd17, 2'd2, 2'd3, 1'b0, 6};

        rst = 1'b1; tick_in = 1'b0; auto_en = 1'b1; man_sel = 2'b00;
        repeat (3) cyc();
        chk("rst_sel",   sel1,   0);
        chk("rst_count", count1, 0);
        chk("rst_wrap",  wrap1,  0);
        chk("rst_mode",  mode1,  1);
        rst = 1'b0;
        repeat (6) cyc();
        chk("settle_mode",  mode1,  1);
        chk("settle_count", count1, 0);

        // AUTO rate stepping for both round settings
        for (int v = 0; v < 7; v++) begin
            apply_ticks(vecs[v].ticks);
            chk($sformatf("v%0d_count", v), count1, vecs[v].exp_count);
            chk($sformatf("v%0d_sel1", v),  sel1,   vecs[v].exp_sel1);
            chk($sformatf("v%0d_sel2", v),  sel2,   vecs[v].exp_sel2);
            chk($sformatf("v%0d_wrap", v),  wrap1,  vecs[v].exp_wrap);
            cyc();
            chk($sformatf("v%0d_wraps", v), wcnt,   vecs[v].exp_wraps);
        end

        // AUTO -> MANUAL at count 17, sel 10; tick inside S_SWITCH ignored
        auto_en = 1'b0; man_sel = 2'b01;
        cyc(); cyc(); cyc();
        chk("sw_count", count1, 0);
        chk("sw_mode",  mode1,  0);
        chk("sw_sel",   sel1,   2);
        tick_in = 1'b1;
        cyc();
        tick_in = 1'b0;
        chk("man_sel1",  sel1,   1);
        chk("man_sel2",  sel2,   1);
        chk("man_count", count1, 0);
        chk("man_mode",  mode1,  0);

        // MANUAL select change at count 9; tick in the change cycle ignored
        cyc();
        apply_ticks(9);
        chk("m9_count", count1, 9);
        cyc();
        man_sel = 2'b11;
        cyc(); cyc();
        tick_in = 1'b1;
        cyc();
        tick_in = 1'b0;
        chk("mchg_sel",   sel1,   3);
        chk("mchg_count", count1, 0);
        cyc();
        apply_ticks(32);
        chk("mwrap_count", count1, 0);
        chk("mwrap_wrap",  wrap1,  1);
        chk("mwrap_sel",   sel1,   3);
        cyc();
        chk("mwrap_wraps", wcnt, 7);

        // Mode edge coincides with the tick at count 31
        apply_ticks(31);
        chk("c31_count", count1, 31);
        cyc();
        auto_en = 1'b1;
        cyc(); cyc();
        tick_in = 1'b1;
        cyc();
        tick_in = 1'b0;
        chk("edge_count", count1, 0);
        chk("edge_wrap",  wrap1,  0);
        chk("edge_mode",  mode1,  0);
        cyc();
        chk("auto_mode",  mode1,  1);
        chk("auto_sel",   sel1,   3);
        chk("edge_wraps", wcnt,   7);

        // Async reset mid-count
        apply_ticks(20);
        chk("pre_count", count1, 20);
        chk("pre_sel",   sel1,   3);
        #2 rst = 1'b1;
        #1;
        chk("arst_count", count1, 0);
        chk("arst_sel",   sel1,   0);
        chk("arst_wrap",  wrap1,  0);
        chk("arst_mode",  mode1,  1);
        chk("arst_sel2",  sel2,   0);
        cyc();
        rst = 1'b0;
        cyc();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

`default_nettype wire
